// File: rtl/rob_dispatch_if.sv
// Decoder-to-dispatch and dispatch-to-ROB signal bundle.
// The dispatch block sits on the slave modport; the stimulus side uses master.
interface rob_dispatch_if #(
  parameter int unsigned OPT_W = 4,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned CNT_W = 3
);
  logic             dec_valid;
  logic             dec_ready;
  logic [OPT_W-1:0] dec_instr_type;
  logic [4:0]       dec_rd;
  logic             dec_writes_rd;
  logic [31:0]      dec_pc;
  logic             rob_full;
  logic             branch_mispredict;
  logic             rob_load;
  logic [OPT_W-1:0] instr_type;
  logic [4:0]       rd;
  logic [31:0]      rob_pc;
  logic [TAG_W-1:0] rob_tag;
  logic             regfile_allocate;
  logic [CNT_W-1:0] iq_count;

  modport slave (
    input  dec_valid, dec_instr_type, dec_rd, dec_writes_rd, dec_pc,
    input  rob_full, branch_mispredict,
    output dec_ready, rob_load, instr_type, rd, rob_pc, rob_tag,
    output regfile_allocate, iq_count
  );

  modport master (
    output dec_valid, dec_instr_type, dec_rd, dec_writes_rd, dec_pc,
    output rob_full, branch_mispredict,
    input  dec_ready, rob_load, instr_type, rd, rob_pc, rob_tag,
    input  regfile_allocate, iq_count
  );
endinterface

// File: rtl/rob_dispatch.sv
// ROB allocation producer: in-order instruction queue feeding the ROB,
// mirroring the ROB tail tag and flushing on branch mispredict.
module rob_dispatch #(
  parameter int unsigned IQ_DEPTH  = 4,
  parameter int unsigned ROB_DEPTH = 8,
  parameter int unsigned TAG_W     = 3,
  parameter int unsigned OPT_W     = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  rob_dispatch_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic [OPT_W-1:0] itype;
    logic [4:0]       rd;
    logic             wr;
    logic [31:0]      pc;
  } iq_entry_t;

  state_t           r_state;
  state_t           w_state_nxt;
  iq_entry_t        r_mem [IQ_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [TAG_W-1:0] r_tag;

  iq_entry_t        w_head;
  iq_entry_t        w_in;
  logic             w_run;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_alloc;

  assign w_head = r_mem[r_head];
  assign w_in   = '{itype: bus.dec_instr_type, rd: bus.dec_rd,
                    wr: bus.dec_writes_rd, pc: bus.dec_pc};

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  // Next state and handshake decode; mispredict and reset gate everything
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_ready     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_alloc     = 1'b0;
    case (r_state)
      RUN:     if (bus.branch_mispredict)  w_state_nxt = FLUSH;
      FLUSH:   if (!bus.branch_mispredict) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    w_run   = reset_n && (r_state == RUN) && !bus.branch_mispredict;
    w_ready = w_run && (r_count < CNT_W'(IQ_DEPTH));
    w_push  = w_ready && bus.dec_valid;
    w_pop   = w_run && (r_count != '0) && !bus.rob_full;
    w_alloc = w_pop && w_head.wr && (w_head.rd != 5'd0);
  end

  // Queue pointers, occupancy and mirrored ROB tail tag
  always_ff @(posedge clk) begin
    if (!reset_n || bus.branch_mispredict) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_tag   <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
        r_tag  <= (r_tag == TAG_W'(ROB_DEPTH - 1)) ? '0 : r_tag + TAG_W'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_in;
  end

  assign bus.dec_ready        = w_ready;
  assign bus.rob_load         = w_pop;
  assign bus.regfile_allocate = w_alloc;
  assign bus.instr_type       = w_head.itype;
  assign bus.rd               = w_head.rd;
  assign bus.rob_pc           = w_head.pc;
  assign bus.rob_tag          = r_tag;
  assign bus.iq_count         = r_count;
endmodule

// File: tb/tb_rob_dispatch.sv
// Directed scenarios plus randomized traffic for rob_dispatch, checked every
// cycle against a queue-based reference model.
module tb_rob_dispatch;
  localparam int unsigned IQ_DEPTH  = 4;
  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned TAG_W     = 3;
  localparam int unsigned OPT_W     = 4;
  localparam int unsigned CNT_W     = 3;

  logic clk = 1'b0;
  logic reset_n;

  rob_dispatch_if #(.OPT_W(OPT_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  rob_dispatch #(
    .IQ_DEPTH(IQ_DEPTH), .ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W), .OPT_W(OPT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ty;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   m_tag;
  bit   m_flush;
  bit   m_known;
  int   n_checks;
  int   n_fail;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge
  task automatic cycle(input logic v, input logic [3:0] ty, input logic [4:0] rdv,
                       input logic wr, input logic [31:0] pc,
                       input logic full, input logic mis, input logic rstn);
    bit   exp_ready, exp_load, exp_alloc;
    ent_t e;
    @(negedge clk);
    reset_n               = rstn;
    bus.dec_valid         = v;
    bus.dec_instr_type    = ty;
    bus.dec_rd            = rdv;
    bus.dec_writes_rd     = wr;
    bus.dec_pc            = pc;
    bus.rob_full          = full;
    bus.branch_mispredict = mis;
    #1;
    exp_ready = rstn && m_known && !m_flush && !mis && (q.size() < IQ_DEPTH);
    exp_load  = rstn && m_known && !m_flush && !mis && (q.size() != 0) && !full;
    exp_alloc = exp_load && q[0].wr && (q[0].rd != 5'd0);
    if (m_known || !rstn) begin
      check_val("dec_ready", 64'(bus.dec_ready), 64'(exp_ready));
      check_val("rob_load", 64'(bus.rob_load), 64'(exp_load));
      check_val("regfile_allocate", 64'(bus.regfile_allocate), 64'(exp_alloc));
    end
    if (m_known && rstn) begin
      check_val("rob_tag", 64'(bus.rob_tag), 64'(m_tag));
      check_val("iq_count", 64'(bus.iq_count), 64'(q.size()));
      if (exp_load) begin
        check_val("instr_type", 64'(bus.instr_type), 64'(q[0].ty));
        check_val("rd", 64'(bus.rd), 64'(q[0].rd));
        check_val("rob_pc", 64'(bus.rob_pc), 64'(q[0].pc));
      end
    end
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      m_tag   = 0;
      m_flush = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (mis) begin
        q.delete();
        m_tag   = 0;
        m_flush = 1'b1;
      end else begin
        m_flush = 1'b0;
        if (exp_load) begin
          void'(q.pop_front());
          m_tag = (m_tag + 1) % ROB_DEPTH;
        end
        if (v && exp_ready) begin
          e.ty = ty; e.rd = rdv; e.wr = wr; e.pc = pc;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input logic full);
    cycle(1'b0, 4'h0, 5'd0, 1'b0, 32'h0, full, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [4:0] rdv, input logic [31:0] pc, input logic full);
    cycle(1'b1, 4'h3, rdv, 1'b1, pc, full, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_tag    = 0;
    m_flush  = 1'b0;
    m_known  = 1'b0;
    reset_n  = 1'b0;
    bus.dec_valid = 1'b0; bus.dec_instr_type = '0; bus.dec_rd = '0;
    bus.dec_writes_rd = 1'b0; bus.dec_pc = '0; bus.rob_full = 1'b0;
    bus.branch_mispredict = 1'b0;

    // Reset then idle
    repeat (2) cycle(1'b0, 4'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check_val("idle_ready", 64'(bus.dec_ready), 64'd1);

    // Single dispatch of a load to x5 at pc 0x60
    cycle(1'b1, 4'h1, 5'd5, 1'b1, 32'h60, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // Back-pressure: five pushes against a full ROB, then drain
    for (int i = 0; i < 5; i++) push(5'(i + 1), 32'h100 + 32'(i * 4), 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b0);

    // Tag wrap with an x0 destination on the third instruction
    cycle(1'b0, 4'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) push((i == 2) ? 5'd0 : 5'(i + 8), 32'h200 + 32'(i * 4), 1'b0);
    repeat (3) idle(1'b0);

    // Mispredict with three queued and tag at 5
    cycle(1'b0, 4'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push(5'd1, 32'h300 + 32'(i * 4), 1'b0);
    repeat (2) idle(1'b0);
    for (int i = 0; i < 3; i++) push(5'd2, 32'h400 + 32'(i * 4), 1'b1);
    cycle(1'b1, 4'h2, 5'd3, 1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 4'h2, 5'd3, 1'b1, 32'h504, 1'b0, 1'b0, 1'b1);
    repeat (2) idle(1'b0);

    // Mid-stream reset with two queued
    for (int i = 0; i < 2; i++) push(5'd4, 32'h600 + 32'(i * 4), 1'b1);
    cycle(1'b1, 4'h0, 5'd4, 1'b1, 32'h608, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r_rd;
      r_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), r_rd,
            1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 3),
            !($urandom_range(0, 99) < 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
